// File: rtl/alsu_core.sv
// alsu_core: handshaked arithmetic-logic-shift unit with a 2W-bit result register.
// MULT iterates one shift-add partial product per cycle; other operations take one cycle.
// Optional build macro ALSU_LED_BLINK_EN: leds blink while err is set (else leds tied to 0).
module alsu_core #(
  parameter int unsigned W              = 3,
  parameter int unsigned LED_W          = 16,
  parameter int unsigned FULL_ADDER     = 1,
  parameter string       INPUT_PRIORITY = "A"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out,
  output logic             err,
  output logic [LED_W-1:0] leds
);

  localparam int unsigned RW     = 2 * W;
  localparam int unsigned SW     = W + 1;
  localparam int unsigned CW     = $clog2(W + 1);
  localparam bit          PrioB  = (INPUT_PRIORITY == "B");
  localparam bit          UseCin = (FULL_ADDER != 0);

  localparam logic [2:0] OpOr     = 3'd0;
  localparam logic [2:0] OpXor    = 3'd1;
  localparam logic [2:0] OpAdd    = 3'd2;
  localparam logic [2:0] OpMult   = 3'd3;
  localparam logic [2:0] OpShift  = 3'd4;
  localparam logic [2:0] OpRotate = 3'd5;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e        state_q;
  logic [RW-1:0] out_q;
  logic [RW-1:0] mcand_q;
  logic [RW-1:0] acc_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic          err_q;
  logic          err_d;

  logic          invalid;
  logic          is_mul;
  logic          sel_b;
  logic          red_b;
  logic          red_bit;
  logic          mul_last;
  logic [W-1:0]  red_src;
  logic [SW-1:0] sum;
  logic [RW-1:0] res;
  logic [RW-1:0] pp_sum;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;
  assign mul_last  = (cnt_q == CW'(W - 1));

  // Decode the presented operation and form the single-cycle result and next err.
  always_comb begin
    invalid = (opcode > OpRotate) ||
              ((red_op_A || red_op_B) && (opcode != OpOr) && (opcode != OpXor));
    is_mul  = !invalid && !bypass_A && !bypass_B && (opcode == OpMult);
    sel_b   = bypass_B && (!bypass_A || PrioB);
    red_b   = red_op_B && (!red_op_A || PrioB);
    red_src = red_b ? B : A;
    red_bit = (opcode == OpXor) ? ^red_src : |red_src;
    sum     = {1'b0, A} + {1'b0, B} + SW'(cin & UseCin);

    res = '0;
    if (!invalid) begin
      if (bypass_A || bypass_B) begin
        res = sel_b ? RW'(B) : RW'(A);
      end else begin
        case (opcode)
          OpOr:     res = (red_op_A || red_op_B) ? RW'(red_bit) : RW'(A | B);
          OpXor:    res = (red_op_A || red_op_B) ? RW'(red_bit) : RW'(A ^ B);
          OpAdd:    res = RW'(sum);
          OpShift:  res = direction ? {out_q[RW-2:0], serial_in} : {serial_in, out_q[RW-1:1]};
          OpRotate: res = direction ? {out_q[RW-2:0], out_q[RW-1]} : {out_q[0], out_q[RW-1:1]};
          default:  res = '0;
        endcase
      end
    end

    pp_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // err changes only when an operation completes.
    err_d = err_q;
    if ((state_q == StIdle) && in_valid && !is_mul) begin
      err_d = invalid;
    end else if ((state_q == StMul) && mul_last) begin
      err_d = 1'b0;
    end
  end

  // Control FSM with registered result, valid and multiplier datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_mul) begin
              mcand_q  <= RW'(A);
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= StMul;
            end else begin
              out_q       <= res;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StMul: begin
          if (mul_last) begin
            out_q       <= pp_sum;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            acc_q    <= pp_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALSU_LED_BLINK_EN
  logic [LED_W-1:0] leds_q;

  // Blink while err is set: all ones on the cycle err rises, then invert every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leds_q <= '0;
    end else if (!err_d) begin
      leds_q <= '0;
    end else if (!err_q) begin
      leds_q <= '1;
    end else begin
      leds_q <= ~leds_q;
    end
  end

  assign leds = leds_q;
`else
  assign leds = '0;
`endif

endmodule

// File: tb/tb_alsu_core.sv
// tb_alsu_core: directed self-checking bench for alsu_core (W=3, FULL_ADDER=1, priority "A").
module tb_alsu_core;

`ifdef ALSU_LED_BLINK_EN
  localparam logic [15:0] LedOn = 16'hFFFF;
`else
  localparam logic [15:0] LedOn = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  A;
  logic [2:0]  B;
  logic [2:0]  opcode;
  logic        cin;
  logic        serial_in;
  logic        direction;
  logic        red_op_A;
  logic        red_op_B;
  logic        bypass_A;
  logic        bypass_B;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out;
  logic        err;
  logic [15:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alsu_core #(
    .W(3),
    .LED_W(16),
    .FULL_ADDER(1),
    .INPUT_PRIORITY("A")
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .opcode(opcode),
    .cin(cin),
    .serial_in(serial_in),
    .direction(direction),
    .red_op_A(red_op_A),
    .red_op_B(red_op_B),
    .bypass_A(bypass_A),
    .bypass_B(bypass_B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .err(err),
    .leds(leds)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    in_valid  = 1'b0;
    A         = 3'd0;
    B         = 3'd0;
    opcode    = 3'd0;
    cin       = 1'b0;
    serial_in = 1'b0;
    direction = 1'b0;
    red_op_A  = 1'b0;
    red_op_B  = 1'b0;
    bypass_A  = 1'b0;
    bypass_B  = 1'b0;
  endtask

  // Present the current fields; returns #1 after the accept edge (cycle t+1).
  task automatic accept(input string tag);
    for (int i = 0; i < 10 && in_ready !== 1'b1; i++) tick();
    check(tag, in_ready, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctl();
    out_ready = 1'b1;
    rst       = 1'b0;
    repeat (3) tick();
    check("rst_out", out, 6'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_leds", leds, 16'h0000);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    tick();

    // ADD 5+6+1 = 12
    A = 3'd5; B = 3'd6; cin = 1'b1; opcode = 3'd2;
    accept("add_accept");
    check("add_out", out, 6'd12);
    check("add_out_valid", out_valid, 1'b1);
    check("add_err", err, 1'b0);
    check("add_in_ready", in_ready, 1'b0);
    tick();
    check("add_idle_valid", out_valid, 1'b0);
    check("add_idle_ready", in_ready, 1'b1);
    check("add_hold", out, 6'd12);

    // ADD carry-out: 7+7+1 = 15
    A = 3'd7; B = 3'd7; cin = 1'b1; opcode = 3'd2;
    accept("add_c_accept");
    check("add_c_out", out, 6'd15);
    tick();

    // MULT 7*7 = 49, valid exactly at t+4
    clear_ctl();
    A = 3'd7; B = 3'd7; opcode = 3'd3;
    accept("mul_accept");
    check("mul_out_hold", out, 6'd15);
    for (int i = 0; i < 3; i++) begin
      check("mul_busy_ready", in_ready, 1'b0);
      check("mul_busy_valid", out_valid, 1'b0);
      tick();
    end
    check("mul_valid", out_valid, 1'b1);
    check("mul_out", out, 6'd49);
    check("mul_done_ready", in_ready, 1'b0);
    tick();
    check("mul_release", out_valid, 1'b0);

    // Bypass overrides MULT: single-cycle B
    clear_ctl();
    A = 3'd7; B = 3'd6; opcode = 3'd3; bypass_B = 1'b1;
    accept("byp_mul_accept");
    check("byp_mul_valid", out_valid, 1'b1);
    check("byp_mul_out", out, 6'd6);
    tick();

    // Both bypasses: A wins
    clear_ctl();
    A = 3'd2; B = 3'd3; opcode = 3'd2; bypass_A = 1'b1; bypass_B = 1'b1;
    accept("byp_both_accept");
    check("byp_both_out", out, 6'd2);
    tick();

    // Both reductions on OR: reduction of A (0) wins over B (1)
    clear_ctl();
    A = 3'd0; B = 3'd7; opcode = 3'd0; red_op_A = 1'b1; red_op_B = 1'b1;
    accept("red_both_accept");
    check("red_both_out", out, 6'd0);
    check("red_both_err", err, 1'b0);
    tick();

    // OR-reduce A=100 -> 1
    clear_ctl();
    A = 3'b100; opcode = 3'd0; red_op_A = 1'b1;
    accept("red_or_accept");
    check("red_or_out", out, 6'd1);
    tick();

    // ADD with reduction is invalid; bypass does not rescue it
    clear_ctl();
    A = 3'd4; opcode = 3'd2; red_op_B = 1'b1; bypass_A = 1'b1;
    accept("inv_accept");
    check("inv_out", out, 6'd0);
    check("inv_err", err, 1'b1);
    check("inv_valid", out_valid, 1'b1);
    check("inv_leds0", leds, LedOn);
    tick();
    check("inv_err_hold", err, 1'b1);
    check("inv_leds1", leds, 16'h0000);
    tick();
    check("inv_leds2", leds, LedOn);

    // Preload out=5 via bypass_A; err clears
    clear_ctl();
    A = 3'd5; opcode = 3'd0; bypass_A = 1'b1;
    accept("preload_accept");
    check("preload_out", out, 6'b000101);
    check("preload_err", err, 1'b0);
    check("preload_leds", leds, 16'h0000);
    tick();

    clear_ctl();
    opcode = 3'd4; direction = 1'b1; serial_in = 1'b1;
    accept("shl_accept");
    check("shl_out", out, 6'b001011);
    tick();

    clear_ctl();
    opcode = 3'd5; direction = 1'b0; serial_in = 1'b0;
    accept("ror_accept");
    check("ror_out", out, 6'b100101);
    tick();

    clear_ctl();
    opcode = 3'd4; direction = 1'b0; serial_in = 1'b0;
    accept("shr_accept");
    check("shr_out", out, 6'b010010);
    tick();

    clear_ctl();
    opcode = 3'd5; direction = 1'b1;
    accept("rol_accept");
    check("rol_out", out, 6'b100100);
    tick();

    // Backpressure on XOR 3^5 = 6; inputs wiggle and are ignored
    clear_ctl();
    out_ready = 1'b0;
    A = 3'd3; B = 3'd5; opcode = 3'd1;
    accept("bp_accept");
    for (int i = 0; i < 5; i++) begin
      check("bp_out", out, 6'd6);
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      A = 3'd1; B = 3'd1; opcode = 3'd2; in_valid = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", in_ready, 1'b1);
    check("bp_idle_valid", out_valid, 1'b0);
    check("bp_idle_out", out, 6'd6);

    // Reset in the middle of MULT
    clear_ctl();
    A = 3'd7; B = 3'd7; opcode = 3'd3;
    accept("mrst_accept");
    tick();
    rst = 1'b0;
    #1;
    check("mrst_out", out, 6'd0);
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("mrst_no_result", out_valid, 1'b0);
      tick();
    end
    check("mrst_out_kept", out, 6'd0);

    clear_ctl();
    A = 3'd1; B = 3'd1; opcode = 3'd2;
    accept("post_accept");
    check("post_out", out, 6'd2);
    check("post_valid", out_valid, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu_core.md
# alsu_core

Parametrised, handshaked arithmetic-logic-shift unit; the next generation of the team's 3-bit ALSU. Operand width is a parameter, operations are accepted through a valid/ready input handshake and results are returned through a valid/ready output handshake. Multiplication runs as an iterative shift-add over `W` cycles; all other operations complete in one cycle. The block sits between an operand-issuing controller and a result consumer, with LEDs driven as an invalid-operation indicator.

## Interface
- `W`, 3: operand width; result width is `2*W`.
- `LED_W`, 16: width of the LED output.
- `FULL_ADDER`, 1: 1 = ADD includes `cin`; 0 = `cin` ignored.
- `INPUT_PRIORITY`, "A": bypass and reduction winner when both A- and B-side controls are set ("A" or "B").

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-low.
- `in_valid`  in  1  operand and control fields are valid.
- `in_ready`  out  1  the block accepts on `in_valid && in_ready`.
- `A`, `B`  in  W  operands.
- `opcode`  in  3  operation: 0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 invalid.
- `cin`  in  1  carry-in for ADD.
- `serial_in`  in  1  shift fill bit.
- `direction`  in  1  1 = left, 0 = right.
- `red_op_A`, `red_op_B`  in  1  reduction select.
- `bypass_A`, `bypass_B`  in  1  pass the operand straight through.
- `out_valid`  out  1  `out` holds a new result.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  2W  result register.
- `err`  out  1  the last accepted operation was invalid.
- `leds`  out  LED_W  invalid indicator.

## Operation
- The FSM has three states: IDLE, MUL, DONE.
- `in_ready` = 1 only in IDLE.
- Accept in IDLE:
  - Invalid operation → DONE.
  - MULT → MUL.
  - Any other operation → DONE.
- Invalid operation: `opcode` 6/7, or (`red_op_A` | `red_op_B`) with `opcode` ∉ {OR, XOR}.
  - Sets `out` = 0 and `err` = 1.
  - Bypass does not override invalid.
- Bypass on a valid operation:
  - `bypass_A` → `out` = zero-extended A; `bypass_B` → zero-extended B.
  - If both are set, `INPUT_PRIORITY` decides.
  - Bypass overrides the opcode.
- OR/XOR:
  - `red_op_A` → `out` = reduction of A, 1 bit, zero-extended.
  - `red_op_B` → reduction of B.
  - If both are set, `INPUT_PRIORITY` decides.
  - Otherwise bitwise A op B, zero-extended.
- ADD: `out` = A + B (+ `cin` if `FULL_ADDER`), W+1 bits, zero-extended.
- MULT: unsigned, 2W bits, one partial product per cycle in MUL, W cycles in total.
- SHIFT and ROTATE operate on the current `out` register by one bit:
  - SHIFT left: {out[2W-2:0], serial_in}.
  - SHIFT right: {serial_in, out[2W-1:1]}.
  - ROTATE fills with the bit shifted out.
- DONE:
  - `out_valid` = 1; leave to IDLE when `out_ready` = 1.
  - `out` holds after the handshake. It changes only on the next completion.
- `err` updates on every completion: 1 if invalid, else 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State → IDLE; `out` = 0; `out_valid` = 0; `err` = 0; `leds` = 0; the multiplier datapath is cleared.
  - Reset during MUL or DONE aborts the operation; no result is emitted.
- Latency, from accept edge t:
  - Non-MULT: `out_valid` = 1 in cycle t+1.
  - MULT: `out_valid` = 1 in cycle t+W+1.
- Throughput: one operation per 2 cycles (non-MULT) with `out_ready` held high.
- Backpressure: `out_valid` and `out` hold stable until `out_ready`; `in_ready` = 0 meanwhile.
- `out_ready` asserted with `out_valid` → `in_ready` = 1 on the next cycle. There is no same-cycle accept/complete.
- Operand inputs are sampled only at the accept edge. Changes during MUL/DONE are ignored.
- `out_ready` in IDLE has no effect.

## Configuration
- `ALSU_LED_BLINK_EN` defined:
  - While `err` = 1, `leds` toggles between all ones and all zeros every clock, starting all ones on the cycle `err` rises.
  - `leds` goes to 0 on the cycle `err` clears.
- Undefined: `leds` is tied to 0. `err` behaviour is unchanged.

## Test plan
- ADD, W=3, FULL_ADDER=1: A=5, B=6, cin=1 → `out`=12, `out_valid` at t+1, `err`=0.
- MULT: A=7, B=7 → `out`=49 exactly at t+4; `in_ready`=0 for cycles t+1..t+4.
- OR with `red_op_A`=1, A=3'b100 → `out`=1. Then opcode=ADD with `red_op_B`=1 → `out`=0, `err`=1, and with the macro `leds`=16'hFFFF, 16'h0000, 16'hFFFF on successive cycles.
- SHIFT: preload `out`=6'b000101 via bypass_A (A=5); SHIFT left with serial_in=1 → 6'b001011; ROTATE right → 6'b100101.
- Backpressure: `out_ready`=0 for 5 cycles after an XOR of A=3, B=5 → `out`=6 stable, `out_valid`=1, `in_ready`=0 throughout; `out_ready`=1 → IDLE next cycle.
- Reset mid-MULT: assert `rst`=0 in cycle t+2 → `out`=0, `out_valid`=0 immediately. After release the next ADD 1+1 → `out`=2.
